// File: rtl/exc_commit_seq.sv
// exc_commit_seq: sequences the side effects of one resolved exception or ERET
// coming out of MEM: CP0 update + full flush (COMMIT), PC redirect with fetch
// handshake (REDIRECT), then a drain window (DRAIN) before the next event.
//
// Optional feature macro: EXC_WATCHDOG_EN
//   defined   : REDIRECT is bounded by REDIRECT_TIMEOUT cycles; expiry sets the
//               sticky redirect_timeout flag and forces IDLE.
//   undefined : REDIRECT waits indefinitely; redirect_timeout is tied to 0.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   exc_valid/exc_is_eret/...     resolved event fields from MEM
//   cp0_epc_i                     forwarded EPC (ERET return address)
//   mem_stall                     event present but not yet committable
//   if_ready                      fetch accepts the redirect this cycle
//   flush_*                       pipeline register flushes
//   cp0_*                         CP0 update controls and data
//   pc_redirect_valid/target      redirect request to PC select
//   busy                          sequencer not idle
//   redirect_timeout              sticky watchdog flag
module exc_commit_seq #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned DRAIN_CYCLES = 2
`ifdef EXC_WATCHDOG_EN
    ,
    parameter int unsigned REDIRECT_TIMEOUT = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic        exc_is_eret,
    input  logic [4:0]  exc_code,
    input  logic        exc_is_delayslot,
    input  logic [31:0] exc_pc,
    input  logic        exc_has_badvaddr,
    input  logic [31:0] exc_badvaddr,
    input  logic [31:0] cp0_epc_i,
    input  logic        mem_stall,
    input  logic        if_ready,
    output logic        flush_ifid,
    output logic        flush_idexe,
    output logic        flush_exemem,
    output logic        flush_memwb,
    output logic        cp0_exc_wr,
    output logic        cp0_exl_clr,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_bd_o,
    output logic [4:0]  cp0_exccode_o,
    output logic        cp0_badvaddr_wr,
    output logic [31:0] cp0_badvaddr_o,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect_target,
    output logic        busy,
    output logic        redirect_timeout
);

    localparam int unsigned DRAIN_W    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_REDIRECT,
        S_DRAIN
    } state_t;

    state_t              state, state_d;
    logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_d;
    logic                latch_en;

    // Event fields captured at acceptance
    logic                l_eret, l_ds, l_hb;
    logic [4:0]          l_code;
    logic [31:0]         l_pc, l_bva, l_epc;

`ifdef EXC_WATCHDOG_EN
    localparam int unsigned WD_W = (REDIRECT_TIMEOUT > 1) ? $clog2(REDIRECT_TIMEOUT) : 1;
    logic [WD_W-1:0]     wd_cnt, wd_cnt_d;
    logic                wd_flag, wd_flag_d;
`endif

    // Next-state logic
    always_comb begin
        state_d     = state;
        drain_cnt_d = drain_cnt;
        latch_en    = 1'b0;
`ifdef EXC_WATCHDOG_EN
        wd_cnt_d    = wd_cnt;
        wd_flag_d   = wd_flag;
`endif
        case (state)
            S_IDLE: begin
                if (exc_valid && !mem_stall) begin
                    latch_en = 1'b1;
                    state_d  = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_REDIRECT;
`ifdef EXC_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
            end
            S_REDIRECT: begin
                if (if_ready) begin
                    if (DRAIN_CYCLES > 0) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_W'(DRAIN_LOAD);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
`ifdef EXC_WATCHDOG_EN
                // Counter value k means k+1 REDIRECT cycles have now elapsed
                else if (wd_cnt == WD_W'(REDIRECT_TIMEOUT - 1)) begin
                    wd_flag_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt + WD_W'(1);
                end
`endif
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt - DRAIN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_d;
            drain_cnt <= drain_cnt_d;
        end
    end

    // Event capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_eret <= 1'b0;
            l_ds   <= 1'b0;
            l_hb   <= 1'b0;
            l_code <= '0;
            l_pc   <= '0;
            l_bva  <= '0;
            l_epc  <= '0;
        end else if (latch_en) begin
            l_eret <= exc_is_eret;
            l_ds   <= exc_is_delayslot;
            l_hb   <= exc_has_badvaddr;
            l_code <= exc_code;
            l_pc   <= exc_pc;
            l_bva  <= exc_badvaddr;
            l_epc  <= cp0_epc_i;
        end
    end

`ifdef EXC_WATCHDOG_EN
    // Redirect watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            wd_cnt  <= wd_cnt_d;
            wd_flag <= wd_flag_d;
        end
    end
    assign redirect_timeout = wd_flag;
`else
    assign redirect_timeout = 1'b0;
`endif

    // Moore output decode; everything idles at 0 outside its owning state
    always_comb begin
        flush_ifid         = 1'b0;
        flush_idexe        = 1'b0;
        flush_exemem       = 1'b0;
        flush_memwb        = 1'b0;
        cp0_exc_wr         = 1'b0;
        cp0_exl_clr        = 1'b0;
        cp0_epc_o          = '0;
        cp0_bd_o           = 1'b0;
        cp0_exccode_o      = '0;
        cp0_badvaddr_wr    = 1'b0;
        cp0_badvaddr_o     = '0;
        pc_redirect_valid  = 1'b0;
        pc_redirect_target = '0;
        busy               = (state != S_IDLE);
        case (state)
            S_COMMIT: begin
                flush_ifid   = 1'b1;
                flush_idexe  = 1'b1;
                flush_exemem = 1'b1;
                flush_memwb  = 1'b1;
                if (l_eret) begin
                    cp0_exl_clr = 1'b1;
                end else begin
                    cp0_exc_wr      = 1'b1;
                    // Delay-slot faults restart at the branch
                    cp0_epc_o       = l_ds ? (l_pc - 32'd4) : l_pc;
                    cp0_bd_o        = l_ds;
                    cp0_exccode_o   = l_code;
                    cp0_badvaddr_wr = l_hb;
                    cp0_badvaddr_o  = l_hb ? l_bva : '0;
                end
            end
            S_REDIRECT: begin
                flush_ifid         = 1'b1;
                pc_redirect_valid  = 1'b1;
                pc_redirect_target = l_eret ? l_epc : EXC_VECTOR;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/exc_commit_seq.md
Name: exc_commit_seq

Overview:
- Sequencer between the MEM-stage exception resolver and the CP0, PC-select and pipeline registers.
- Accepts one resolved exception or ERET and commits its side effects in a fixed order: CP0 state update with pipeline flush, then PC redirect with fetch handshake, then drain window.
- Blocks re-entry until the pipeline has refilled.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry address.
- DRAIN_CYCLES, 2, cycles after redirect during which new exceptions are ignored (0 allowed).
- REDIRECT_TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- exc_valid  in  1  resolved exception/ERET present at MEM
- exc_is_eret  in  1  event is ERET
- exc_code  in  5  Cause.ExcCode value (0 = interrupt)
- exc_is_delayslot  in  1  faulting instruction is in a delay slot
- exc_pc  in  32  PC of faulting instruction
- exc_has_badvaddr  in  1  BadVAddr must be written
- exc_badvaddr  in  32  faulting address
- cp0_epc_i  in  32  forwarded latest EPC
- mem_stall  in  1  MEM stage stalled; event not yet committable
- if_ready  in  1  fetch accepts redirect this cycle
- flush_ifid, flush_idexe, flush_exemem, flush_memwb  out  1 each  pipeline flushes
- cp0_exc_wr  out  1  write EPC/Cause.BD/Cause.ExcCode, set Status.EXL
- cp0_exl_clr  out  1  clear Status.EXL (ERET)
- cp0_epc_o  out  32  EPC value to write
- cp0_bd_o  out  1  Cause.BD
- cp0_exccode_o  out  5  Cause.ExcCode
- cp0_badvaddr_wr  out  1  BadVAddr write enable
- cp0_badvaddr_o  out  32  BadVAddr value
- pc_redirect_valid  out  1  redirect request to PC select
- pc_redirect_target  out  32  redirect address
- busy  out  1  state != IDLE
- redirect_timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset: state IDLE, all latches and outputs 0 (pc_redirect_target 0, redirect_timeout 0). Reset asserted mid-sequence aborts to IDLE immediately.
- States: IDLE, COMMIT, REDIRECT, DRAIN.
- Outputs are Moore, decoded from registered state and latched fields.
- IDLE:
  - If exc_valid=1 and mem_stall=0 at a clock edge, latch all exc_* inputs and cp0_epc_i, then go to COMMIT.
  - If exc_valid=1 and mem_stall=1, hold in IDLE and latch nothing.
- COMMIT (exactly 1 cycle):
  - All four flushes = 1.
  - Exception: cp0_exc_wr=1; cp0_epc_o = delayslot ? pc-4 : pc (mod 2^32); cp0_bd_o = delayslot; cp0_exccode_o = code; cp0_badvaddr_wr = has_badvaddr.
  - ERET: cp0_exl_clr=1, no CP0 writes.
  - Always go to REDIRECT.
- REDIRECT:
  - pc_redirect_valid=1; flush_ifid=1, other flushes 0.
  - Target = ERET ? latched cp0_epc_i : EXC_VECTOR; target stable while waiting.
  - Leave on the first edge with if_ready=1: to DRAIN if DRAIN_CYCLES>0, else IDLE.
- DRAIN:
  - Down-counter loaded with DRAIN_CYCLES-1 on entry; all outputs except busy are 0.
  - Return to IDLE when the counter reaches 0.
- exc_valid in any non-IDLE state is ignored; no queueing.
- Latency: exc_valid sampled at edge N gives COMMIT in cycle N+1. Earliest redirect acceptance is at edge N+2.
- busy=1 in COMMIT, REDIRECT and DRAIN.
- cp0_exc_wr and cp0_exl_clr are never asserted in the same cycle.

Optional Feature:
- Macro: EXC_WATCHDOG_EN.
- Defined:
  - Cycle counter runs while in REDIRECT.
  - If REDIRECT_TIMEOUT cycles elapse without if_ready, set redirect_timeout (sticky until rst) and force IDLE.
  - Counter clears on REDIRECT entry.
- Undefined:
  - No counter; REDIRECT waits indefinitely.
  - redirect_timeout tied to 0.

Test Plan:
- Syscall (code 8), pc=0x80001000, not delay slot, if_ready=1 -> COMMIT: EPC=0x80001000, exccode=8, BD=0, 4 flushes; next cycle redirect target 0xBFC00380; busy for 4 cycles total.
- AdEL in delay slot, pc=0x80002004, badvaddr=0x00000003 -> EPC=0x80002000, BD=1, badvaddr_wr=1 with 0x00000003.
- ERET with cp0_epc_i=0x80003000 -> exl_clr=1, cp0_exc_wr=0, redirect target 0x80003000.
- exc_valid with mem_stall=1 for 3 cycles, then 0 -> no output activity until mem_stall drops; a second exc_valid during DRAIN is ignored.
- if_ready held low 10 cycles in REDIRECT -> valid and target stable for all 10 cycles, exit on the first high; rst pulse in REDIRECT -> all outputs 0 asynchronously.
- EXC_WATCHDOG_EN, REDIRECT_TIMEOUT=4, if_ready=0 -> after 4 REDIRECT cycles redirect_timeout=1 and state returns to IDLE.
